// File: rtl/tetris_pkg.sv
// Shared constants for the tetris game logic and its line-clear engine.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Board geometry, address widths and the state codes of both FSMs live here
// so that gamelogic and line_clear_engine agree on every encoding,
// in particular on the S_CLEAR hand-off state.
package tetris_pkg;

   // Board geometry: x = 0..BOARD_W-1 across, y = 0 (top) .. BOARD_H-1 (floor).
   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;
   localparam int XW      = 4;
   localparam int YW      = 5;

   // One board row, indexed by column.
   typedef logic [BOARD_W-1:0] row_t;

   // line_clear_engine FSM encodings.
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_READ   = 3'd1;
   localparam logic [2:0] S_DECIDE = 3'd2;
   localparam logic [2:0] S_WRITE  = 3'd3;
   localparam logic [2:0] S_FILL   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   // gamelogic FSM encodings. gamelogic pulses the engine's start while in
   // S_CLEAR and hands the board ports over for as long as busy is high.
   localparam logic [2:0] S_INIT   = 3'd0;
   localparam logic [2:0] S_SPAWN  = 3'd1;
   localparam logic [2:0] S_FALL   = 3'd2;
   localparam logic [2:0] S_LOCK   = 3'd3;
   localparam logic [2:0] S_CLEAR  = 3'd4;
   localparam logic [2:0] S_OVER   = 3'd5;

endpackage

// File: rtl/line_clear_engine.sv
// Removes full rows from the board store, compacts the rest down, zero-fills the top.
// Latency: 1 + H*(W+2) + moved_rows*W + lines*W + 1 cycles from accepted start to end of done.
// Backpressure: none; start is only honoured in S_IDLE, ignored while busy (including S_DONE).
//
// Ports:
//   CLOCK_50, resetn          clock, asynchronous active-low reset
//   start                     one-cycle request, sampled in S_IDLE only
//   busy, done, lines         status: busy outside S_IDLE, done pulse, rows removed
//   board_rx/ry, board_rdata  read port; rdata is valid the cycle after rx/ry
//   board_we/wx/wy/wdata      write port, one cell per cycle
// All outputs are registered. Their next values are computed from the next
// state, so each output lines up with the state that produced it.
module line_clear_engine
   import tetris_pkg::*;
(
   input  logic          CLOCK_50,
   input  logic          resetn,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [YW-1:0] lines,
   output logic [XW-1:0] board_rx,
   output logic [YW-1:0] board_ry,
   input  logic          board_rdata,
   output logic          board_we,
   output logic [XW-1:0] board_wx,
   output logic [YW-1:0] board_wy,
   output logic          board_wdata
);

   localparam logic [XW-1:0] ONE_X     = XW'(1);
   localparam logic [YW-1:0] ONE_Y     = YW'(1);
   localparam logic [XW-1:0] C_LAST    = XW'(BOARD_W - 1);
   localparam logic [XW-1:0] C_END     = XW'(BOARD_W);
   localparam logic [YW-1:0] ROW_FLOOR = YW'(BOARD_H - 1);
   localparam logic [YW-1:0] LINES_MAX = YW'(BOARD_H);

   // FSM and datapath state
   logic [2:0]    state_q, state_d;
   logic [YW-1:0] r_q, r_d;          // source row being examined
   logic [YW-1:0] d_q, d_d;          // destination row for the next surviving row
   logic [XW-1:0] c_q, c_d;          // column counter, 0..BOARD_W
   row_t          row_q, row_d;      // captured source row
   logic          full_q, full_d;    // AND of every captured cell of the row
   logic [YW-1:0] lines_q, lines_d;

   // Registered outputs
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [XW-1:0] rx_q, rx_d;
   logic [YW-1:0] ry_q, ry_d;
   logic          we_q, we_d;
   logic [XW-1:0] wx_q, wx_d;
   logic [YW-1:0] wy_q, wy_d;
   logic          wdata_q, wdata_d;

   // Set when the current row has been dealt with and the scan moves upward.
   logic          next_row;
   // The fill ends on row 0; this flag avoids ever comparing an underflowed d.
   logic          fill_last_row;

   assign fill_last_row = (d_q == '0);

   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      d_d      = d_q;
      c_d      = c_q;
      row_d    = row_q;
      full_d   = full_q;
      lines_d  = lines_q;
      next_row = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               r_d     = ROW_FLOOR;
               d_d     = ROW_FLOOR;
               lines_d = '0;
               c_d     = '0;
               full_d  = 1'b1;
               state_d = S_READ;
            end
         end

         // Addresses go out for c = 0..W-1; data for column c-1 returns
         // while column c is being addressed, hence W+1 cycles per row.
         S_READ: begin
            if (c_q != '0) begin
               row_d[c_q - ONE_X] = board_rdata;
               full_d             = full_q & board_rdata;
            end
            if (c_q == C_END) begin
               state_d = S_DECIDE;
            end else begin
               c_d = c_q + ONE_X;
            end
         end

         S_DECIDE: begin
            c_d = '0;
            if (full_q) begin
               // Full row is dropped: the destination stays put.
               if (lines_q != LINES_MAX) begin
                  lines_d = lines_q + ONE_Y;
               end
               next_row = 1'b1;
            end else if (d_q == r_q) begin
               // Nothing cleared below yet, so the row is already in place.
               // d==r can only hold while no line has been removed; when
               // r reaches 0 that way the fill is skipped, so d just stops.
               if (d_q != '0) begin
                  d_d = d_q - ONE_Y;
               end
               next_row = 1'b1;
            end else begin
               state_d = S_WRITE;
            end
         end

         S_WRITE: begin
            if (c_q == C_LAST) begin
               // d > r >= 0 here, so this never wraps.
               d_d      = d_q - ONE_Y;
               next_row = 1'b1;
            end else begin
               c_d = c_q + ONE_X;
            end
         end

         // Entered with c = C_END as a one-cycle decision slot; rows
         // d..0 are then zeroed with the same column sweep as S_WRITE.
         S_FILL: begin
            if (c_q == C_END) begin
               if (lines_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  c_d = '0;
               end
            end else if (c_q == C_LAST) begin
               if (fill_last_row) begin
                  state_d = S_DONE;
               end else begin
                  d_d = d_q - ONE_Y;
                  c_d = '0;
               end
            end else begin
               c_d = c_q + ONE_X;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Move up one row, or finish the scan once the top row is handled.
      if (next_row) begin
         if (r_q == '0) begin
            state_d = S_FILL;
            c_d     = C_END;
         end else begin
            r_d     = r_q - ONE_Y;
            c_d     = '0;
            full_d  = 1'b1;
            state_d = S_READ;
         end
      end

      // Outputs for the cycle after this edge, derived from the next state.
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);

      rx_d    = '0;
      ry_d    = '0;
      if (state_d == S_READ) begin
         ry_d = r_d;
         if (c_d != C_END) begin
            rx_d = c_d;
         end
      end

      we_d    = 1'b0;
      wx_d    = '0;
      wy_d    = '0;
      wdata_d = 1'b0;
      if (state_d == S_WRITE) begin
         we_d    = 1'b1;
         wx_d    = c_d;
         wy_d    = d_d;
         wdata_d = row_d[c_d];
      end else if (state_d == S_FILL && c_d != C_END) begin
         we_d    = 1'b1;
         wx_d    = c_d;
         wy_d    = d_d;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         d_q     <= '0;
         c_q     <= '0;
         row_q   <= '0;
         full_q  <= 1'b0;
         lines_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rx_q    <= '0;
         ry_q    <= '0;
         we_q    <= 1'b0;
         wx_q    <= '0;
         wy_q    <= '0;
         wdata_q <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         d_q     <= d_d;
         c_q     <= c_d;
         row_q   <= row_d;
         full_q  <= full_d;
         lines_q <= lines_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rx_q    <= rx_d;
         ry_q    <= ry_d;
         we_q    <= we_d;
         wx_q    <= wx_d;
         wy_q    <= wy_d;
         wdata_q <= wdata_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign lines       = lines_q;
   assign board_rx    = rx_q;
   assign board_ry    = ry_q;
   assign board_we    = we_q;
   assign board_wx    = wx_q;
   assign board_wy    = wy_q;
   assign board_wdata = wdata_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: board memory with 1-cycle registered read,
// a row-level model of the clear and a per-cycle compare process.
module tb_line_clear_engine;
   import tetris_pkg::*;

   logic          CLOCK_50 = 1'b0;
   logic          resetn;
   logic          start;
   logic          busy, done;
   logic [YW-1:0] lines;
   logic [XW-1:0] board_rx, board_wx;
   logic [YW-1:0] board_ry, board_wy;
   logic          board_rdata, board_we, board_wdata;

   line_clear_engine dut (
      .CLOCK_50    (CLOCK_50),
      .resetn      (resetn),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .lines       (lines),
      .board_rx    (board_rx),
      .board_ry    (board_ry),
      .board_rdata (board_rdata),
      .board_we    (board_we),
      .board_wx    (board_wx),
      .board_wy    (board_wy),
      .board_wdata (board_wdata)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int cyc = 0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   // Board store: registered read, one-cell write, bulk load from the bench.
   row_t mem [BOARD_H];
   row_t init_rows [BOARD_H];
   logic tb_load = 1'b0;

   always @(posedge CLOCK_50) begin
      board_rdata <= mem[board_ry][board_rx];
      if (tb_load) begin
         for (int y = 0; y < BOARD_H; y++) mem[y] <= init_rows[y];
      end else if (board_we) begin
         mem[board_wy][board_wx] <= board_wdata;
      end
   end

   // Model: expected final board, write sequence and busy window.
   typedef struct packed {
      logic [YW-1:0] y;
      logic [XW-1:0] x;
      logic          d;
   } wr_t;

   row_t exp_rows [BOARD_H];
   wr_t  exp_wr [$];
   int   exp_lines, exp_dur, exp_writes;
   int   t_acc, start_cyc, done_delay;
   int   we_cnt, done_cnt, mon_rel;
   bit   mon_en = 1'b0;
   wr_t  mon_w, tmp_w;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Surviving rows stack from the floor in scan order; a row is written
   // only when something below it was cleared; the vacated top is zeroed.
   task automatic build_model();
      int k, moved;
      k = BOARD_H - 1;
      moved = 0;
      exp_lines = 0;
      exp_wr.delete();
      for (int r = BOARD_H - 1; r >= 0; r--) begin
         if (init_rows[r] == {BOARD_W{1'b1}}) begin
            exp_lines++;
         end else begin
            exp_rows[k] = init_rows[r];
            if (k != r) begin
               moved++;
               for (int x = 0; x < BOARD_W; x++) begin
                  tmp_w.y = YW'(k); tmp_w.x = XW'(x); tmp_w.d = init_rows[r][x];
                  exp_wr.push_back(tmp_w);
               end
            end
            k--;
         end
      end
      for (int y = k; y >= 0; y--) begin
         exp_rows[y] = '0;
         for (int x = 0; x < BOARD_W; x++) begin
            tmp_w.y = YW'(y); tmp_w.x = XW'(x); tmp_w.d = 1'b0;
            exp_wr.push_back(tmp_w);
         end
      end
      exp_writes = exp_wr.size();
      exp_dur = 1 + BOARD_H * (BOARD_W + 2) + moved * BOARD_W + exp_lines * BOARD_W + 1;
   endtask

   // Compare process: busy window, done cycle and every write, each cycle.
   always @(negedge CLOCK_50) begin
      if (mon_en) begin
         mon_rel = cyc - t_acc;
         chk("busy_window", busy, (mon_rel >= 0 && mon_rel < exp_dur));
         chk("done_cycle", done, (mon_rel == exp_dur - 1));
         if (done) done_cnt++;
         if (board_we) begin
            we_cnt++;
            if (exp_wr.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_write: got y=%0d x=%0d d=%0b, expected no write (cycle %0d)",
                        board_wy, board_wx, board_wdata, cyc);
            end else begin
               mon_w = exp_wr.pop_front();
               chk("write_y_x_data", {board_wy, board_wx, board_wdata}, mon_w);
            end
         end
      end
   end

   task automatic begin_clear();
      mon_en = 1'b0;
      build_model();
      we_cnt = 0;
      done_cnt = 0;
      @(negedge CLOCK_50);
      tb_load = 1'b1;
      @(negedge CLOCK_50);
      tb_load = 1'b0;
      @(negedge CLOCK_50);
      start = 1'b1;
      start_cyc = cyc;
      t_acc = cyc + 1;
      mon_en = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
   endtask

   task automatic finish_clear(input string nm, input bit poke_at_done);
      bit seen;
      seen = 1'b0;
      done_delay = -1;
      for (int i = 0; i < exp_dur + 20 && !seen; i++) begin
         @(negedge CLOCK_50);
         if (done) begin
            seen = 1'b1;
            done_delay = cyc - start_cyc;
         end
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_done_timeout: got no done, expected done within %0d cycles", nm, exp_dur + 20);
      end
      if (poke_at_done && seen) begin
         start = 1'b1;   // sampled while in S_DONE: must be ignored
         @(negedge CLOCK_50);
         start = 1'b0;
      end
      repeat (3) @(negedge CLOCK_50);
      chk({nm, "_busy_after"}, busy, 0);
      chk({nm, "_lines_model"}, lines, exp_lines);
      chk({nm, "_writes_left"}, exp_wr.size(), 0);
      chk({nm, "_we_cycles_model"}, we_cnt, exp_writes);
      chk({nm, "_done_pulses"}, done_cnt, 1);
      for (int y = 0; y < BOARD_H; y++)
         chk($sformatf("%s_row%0d", nm, y), mem[y], exp_rows[y]);
   endtask

   task automatic clear_init();
      for (int y = 0; y < BOARD_H; y++) init_rows[y] = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
      n_errors++;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      clear_init();
      repeat (3) @(negedge CLOCK_50);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_lines", lines, 0);
      chk("rst_we", board_we, 0);
      chk("rst_rx", board_rx, 0);
      chk("rst_ry", board_ry, 0);
      chk("rst_wx", board_wx, 0);
      chk("rst_wy", board_wy, 0);
      chk("rst_wdata", board_wdata, 0);
      resetn = 1'b1;

      // Empty board; a start coinciding with done must be ignored.
      clear_init();
      begin_clear();
      finish_clear("empty", 1'b1);
      chk("empty_lines", lines, 0);
      chk("empty_we_cycles", we_cnt, 0);
      chk("empty_done_delay", done_delay, 242);

      // Floor full: the 19 empty rows each move down one, then row 0 is zeroed.
      clear_init();
      init_rows[19] = '1;
      begin_clear();
      finish_clear("floor", 1'b0);
      chk("floor_lines", lines, 1);
      chk("floor_we_cycles", we_cnt, 200);
      chk("floor_row0", mem[0], 0);

      // Two full rows interleaved with patterned rows.
      clear_init();
      init_rows[19] = '1;
      init_rows[18] = 10'b1010101010;
      init_rows[17] = '1;
      init_rows[16] = 10'b1100000000;
      begin_clear();
      finish_clear("two", 1'b0);
      chk("two_lines", lines, 2);
      chk("two_row19", mem[19], 10'b1010101010);
      chk("two_row18", mem[18], 10'b1100000000);
      chk("two_row1", mem[1], 0);
      chk("two_row0", mem[0], 0);

      // Every row full.
      for (int y = 0; y < BOARD_H; y++) init_rows[y] = '1;
      begin_clear();
      finish_clear("all", 1'b0);
      chk("all_lines", lines, 20);
      chk("all_done_once", done_cnt, 1);
      chk("all_we_cycles", we_cnt, 200);
      chk("all_done_delay", done_delay, 442);

      // Only the top row full, plus two isolated cells below.
      clear_init();
      init_rows[0] = '1;
      init_rows[19][3] = 1'b1;
      init_rows[10][9] = 1'b1;
      begin_clear();
      finish_clear("top", 1'b0);
      chk("top_lines", lines, 1);
      chk("top_cell_3_19", mem[19][3], 1);
      chk("top_cell_9_10", mem[10][9], 1);
      chk("top_row0", mem[0], 0);
      chk("top_we_cycles", we_cnt, 10);

      // Restart attempt mid-run, then reset mid-run, then a clean rerun.
      clear_init();
      init_rows[19] = '1;
      init_rows[18] = 10'b1010101010;
      init_rows[17] = '1;
      init_rows[16] = 10'b1100000000;
      begin_clear();
      while (cyc < start_cyc + 50) @(negedge CLOCK_50);
      start = 1'b1;
      chk("restart_busy", busy, 1);
      @(negedge CLOCK_50);
      start = 1'b0;
      chk("restart_lines", lines, 2);
      while (cyc < start_cyc + 100) @(negedge CLOCK_50);
      mon_en = 1'b0;
      #2 resetn = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_we", board_we, 0);
      chk("midrst_done", done, 0);
      chk("midrst_lines", lines, 0);
      exp_wr.delete();
      repeat (2) @(negedge CLOCK_50);
      resetn = 1'b1;
      begin_clear();
      finish_clear("rerun", 1'b0);
      chk("rerun_lines", lines, 2);
      chk("rerun_row19", mem[19], 10'b1010101010);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
